// File: rtl/idma_w_beat_gen_axi_pkg.sv
// Shared types for the AXI W beat generator: request layout, bus widths and FSM states.
// All bus widths derive from DataWidth here, so the interface and the RTL always agree.
package idma_w_beat_gen_axi_pkg;

    localparam int unsigned DataWidth     = 32;
    localparam int unsigned StrbWidth     = DataWidth / 8;
    localparam int unsigned OffsetWidth   = $clog2(StrbWidth);
    localparam int unsigned NumBeatsWidth = 8;

    typedef logic [DataWidth-1:0]     data_t;
    typedef logic [StrbWidth-1:0]     strb_t;
    typedef logic [OffsetWidth-1:0]   offset_t;
    typedef logic [NumBeatsWidth-1:0] num_beats_t;

    typedef enum logic [2:0] {
        ProtoAxi     = 3'd0,
        ProtoAxiLite = 3'd1,
        ProtoObi     = 3'd2,
        ProtoInit    = 3'd3
    } protocol_e;

    // num_beats follows AXI len encoding: 0 means a single beat.
    typedef struct packed {
        protocol_e  dst_protocol;
        logic       dst_head;
        offset_t    offset;
        offset_t    tailer;
        offset_t    shift;
        num_beats_t num_beats;
        logic       is_single;
    } w_dp_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/idma_w_beat_gen_axi_if.sv
// Request, dataflow-buffer and AXI W signals of the beat generator in one bundle.
// The master modport is the beat generator itself; slave is its environment.
interface idma_w_beat_gen_axi_if;
    import idma_w_beat_gen_axi_pkg::*;

    w_dp_req_t dp_req_i;
    logic      dp_valid_i;
    logic      dp_ready_o;

    data_t     buf_data_i;
    strb_t     buf_valid_i;
    strb_t     buf_ready_o;

    data_t     w_data_o;
    strb_t     w_strb_o;
    logic      w_last_o;
    logic      w_valid_o;
    logic      w_ready_i;

    modport master (
        input  dp_req_i, dp_valid_i, buf_data_i, buf_valid_i, w_ready_i,
        output dp_ready_o, buf_ready_o, w_data_o, w_strb_o, w_last_o, w_valid_o
    );

    modport slave (
        output dp_req_i, dp_valid_i, buf_data_i, buf_valid_i, w_ready_i,
        input  dp_ready_o, buf_ready_o, w_data_o, w_strb_o, w_last_o, w_valid_o
    );

endinterface

// File: rtl/idma_w_beat_gen_axi_strb_gen.sv
// Byte-strobe generator: first beat masks lanes below offset, last beat masks lanes at or
// above a non-zero tailer, a single beat applies both, middle beats strobe every lane.
module idma_w_beat_gen_axi_strb_gen
    import idma_w_beat_gen_axi_pkg::*;
(
    input  offset_t offset_i,
    input  offset_t tailer_i,
    input  logic    first_i,
    input  logic    last_i,
    output strb_t   strb_o
);

    strb_t first_mask;
    strb_t last_mask;

    always_comb begin
        first_mask = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            first_mask[i] = (i >= int'(offset_i));
        end
        last_mask = (tailer_i == '0) ? '1 : ((strb_t'(1) << tailer_i) - strb_t'(1));
        strb_o    = (first_i ? first_mask : '1) & (last_i ? last_mask : '1);
    end

endmodule

// File: rtl/idma_w_beat_gen_axi.sv
// AXI W beat generator: queues legalized write requests and emits strobed W beats with WLAST.
// Define IDMA_W_BEAT_GEN_STALL_CNT_EN to add saturating backpressure/data-starvation counters.
module idma_w_beat_gen_axi
    import idma_w_beat_gen_axi_pkg::*;
#(
    parameter int unsigned ReqFifoDepth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    idma_w_beat_gen_axi_if.master        bus,
    output logic                         burst_done_o,
    output logic                         busy_o
`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_bp_cnt_o,
    output logic [31:0]                  stall_data_cnt_o
`endif
);

    localparam int unsigned PtrWidth = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
    localparam int unsigned CntWidth = $clog2(ReqFifoDepth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    w_dp_req_t  mem_q [ReqFifoDepth];
    ptr_t       wr_ptr_q, rd_ptr_q;
    cnt_t       cnt_q, cnt_d;
    state_e     state_q;
    num_beats_t beat_cnt_q;

    w_dp_req_t  head;
    strb_t      strb_raw;
    logic       full, empty, push, pop;
    logic       in_burst, is_first, is_last, w_hs, last_hs;
    logic       unused_req_bits;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(ReqFifoDepth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Ready is derived from the registered fill level only, never from the W side.
    assign full  = (cnt_q == cnt_t'(ReqFifoDepth));
    assign empty = (cnt_q == '0);
    assign push  = bus.dp_valid_i & ~full;
    assign pop   = last_hs;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.dp_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign in_burst = (state_q == BURST);
    assign is_first = (beat_cnt_q == '0);
    assign is_last  = (beat_cnt_q == head.num_beats);

    idma_w_beat_gen_axi_strb_gen i_strb_gen (
        .offset_i (head.offset),
        .tailer_i (head.tailer),
        .first_i  (is_first),
        .last_i   (is_last),
        .strb_o   (strb_raw)
    );

    // A beat may only go out once every lane it strobes is present in the buffer.
    assign bus.w_valid_o   = in_burst & (&(bus.buf_valid_i | ~strb_raw));
    assign bus.w_strb_o    = in_burst ? strb_raw : '0;
    assign bus.w_last_o    = in_burst & is_last;
    assign bus.w_data_o    = in_burst ? bus.buf_data_i : '0;
    assign w_hs            = bus.w_valid_o & bus.w_ready_i;
    assign last_hs         = w_hs & is_last;
    assign bus.buf_ready_o = bus.w_strb_o & {StrbWidth{w_hs}};
    assign bus.dp_ready_o  = ~full;
    assign burst_done_o    = last_hs;
    assign busy_o          = in_burst | ~empty;

    assign unused_req_bits = ^{head.dst_protocol, head.dst_head, head.shift, head.is_single};

    // The head stays queued for the whole burst, so staying in BURST after WLAST means
    // the next request is already stored and its beat 0 follows without a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (push) state_q <= BURST;
                end
                BURST: begin
                    if (last_hs) begin
                        beat_cnt_q <= '0;
                        if (cnt_d == '0) state_q <= IDLE;
                    end else if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + num_beats_t'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
    logic [31:0] stall_bp_cnt_q, stall_data_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_bp_cnt_q   <= '0;
            stall_data_cnt_q <= '0;
        end else begin
            if (bus.w_valid_o && !bus.w_ready_i && (stall_bp_cnt_q != '1)) begin
                stall_bp_cnt_q <= stall_bp_cnt_q + 32'd1;
            end
            if (in_burst && !bus.w_valid_o && (stall_data_cnt_q != '1)) begin
                stall_data_cnt_q <= stall_data_cnt_q + 32'd1;
            end
        end
    end

    assign stall_bp_cnt_o   = stall_bp_cnt_q;
    assign stall_data_cnt_o = stall_data_cnt_q;
`endif

endmodule

// File: tb/tb_idma_w_beat_gen_axi.sv
// Testbench for idma_w_beat_gen_axi: table of requests with hand-derived strobes checked by
// a beat scoreboard, plus sequences for back-to-back, backpressure, starvation and reset.
module tb_idma_w_beat_gen_axi;
    import idma_w_beat_gen_axi_pkg::*;

    typedef struct packed {
        logic [1:0]      offset;
        logic [1:0]      tailer;
        logic [7:0]      numBeats;
        logic [3:0][3:0] expStrb;
    } vec_t;

    typedef struct packed {
        logic [3:0] strb;
        logic       last;
    } sb_t;

    logic clk;
    logic rstN;
    logic burstDone;
    logic busy;
    logic holdData;
    int   vecCount;
    int   missCount;
    sb_t  sbQ [$];
    vec_t vecs [6];

`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
    logic [31:0] bpCnt;
    logic [31:0] dataCnt;
`endif

    idma_w_beat_gen_axi_if busIf ();

    idma_w_beat_gen_axi #(
        .ReqFifoDepth (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .bus          (busIf),
        .burst_done_o (burstDone),
        .busy_o       (busy)
`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
        ,
        .stall_bp_cnt_o   (bpCnt),
        .stall_data_cnt_o (dataCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer data changes a little after each rising edge unless a test freezes it.
    always @(posedge clk) begin
        #2;
        if (!holdData) busIf.buf_data_i = $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [1:0] off, input logic [1:0] tail,
                                   input logic [7:0] nb, input logic [3:0] s0,
                                   input logic [3:0] s1, input logic [3:0] s2,
                                   input logic [3:0] s3);
        vec_t v;
        v.offset     = off;
        v.tailer     = tail;
        v.numBeats   = nb;
        v.expStrb[0] = s0;
        v.expStrb[1] = s1;
        v.expStrb[2] = s2;
        v.expStrb[3] = s3;
        return v;
    endfunction

    // Scoreboard: every W handshake pops one expected beat; otherwise no pop/done allowed.
    always @(negedge clk) begin
        if (rstN) begin
            if (busIf.w_valid_o && busIf.w_ready_i) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected beat wvalid", 32'(busIf.w_valid_o), 32'd0);
                end else begin
                    sb_t e;
                    e = sbQ.pop_front();
                    checkOutput("wstrb", 32'(busIf.w_strb_o), 32'(e.strb));
                    checkOutput("wlast", 32'(busIf.w_last_o), 32'(e.last));
                    checkOutput("buf_ready", 32'(busIf.buf_ready_o), 32'(e.strb));
                    checkOutput("burst_done", 32'(burstDone), 32'(e.last));
                    checkOutput("wdata", busIf.w_data_o, busIf.buf_data_i);
                end
            end else begin
                checkOutput("buf_ready idle", 32'(busIf.buf_ready_o), 32'd0);
                checkOutput("burst_done idle", 32'(burstDone), 32'd0);
            end
        end
    end

    // Queues the expected beats, then holds dp_valid until the request is accepted.
    task automatic applyStimulus(input vec_t v);
        logic accepted;
        for (int b = 0; b <= int'(v.numBeats); b++) begin
            sb_t e;
            e.strb = v.expStrb[b];
            e.last = (b == int'(v.numBeats));
            sbQ.push_back(e);
        end
        busIf.dp_req_i           = '0;
        busIf.dp_req_i.offset    = v.offset;
        busIf.dp_req_i.tailer    = v.tailer;
        busIf.dp_req_i.num_beats = v.numBeats;
        busIf.dp_req_i.is_single = (v.numBeats == 8'd0);
        busIf.dp_valid_i         = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = busIf.dp_ready_o;
            @(posedge clk);
            #1;
        end
        busIf.dp_valid_i = 1'b0;
        checkOutput("dp accepted", 32'(accepted), 32'd1);
    endtask

    task automatic waitDrain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = (sbQ.size() == 0) && !busy;
        end
        checkOutput("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        sbQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int     n;
        logic [31:0] savedData;
        vecCount  = 0;
        missCount = 0;
        holdData  = 1'b0;
        rstN      = 1'b0;
        busIf.dp_req_i    = '0;
        busIf.dp_valid_i  = 1'b0;
        busIf.buf_data_i  = '0;
        busIf.buf_valid_i = 4'b1111;
        busIf.w_ready_i   = 1'b0;

        vecs[0] = mkVec(2'd1, 2'd3, 8'd0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
        vecs[1] = mkVec(2'd2, 2'd1, 8'd2, 4'b1100, 4'b1111, 4'b0001, 4'b0000);
        vecs[2] = mkVec(2'd0, 2'd0, 8'd1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        vecs[3] = mkVec(2'd3, 2'd0, 8'd3, 4'b1000, 4'b1111, 4'b1111, 4'b1111);
        vecs[4] = mkVec(2'd0, 2'd2, 8'd1, 4'b1111, 4'b0011, 4'b0000, 4'b0000);
        vecs[5] = mkVec(2'd1, 2'd0, 8'd0, 4'b1110, 4'b0000, 4'b0000, 4'b0000);

        $display("[TB] reset values");
        repeat (2) @(negedge clk);
        checkOutput("rst dp_ready", 32'(busIf.dp_ready_o), 32'd1);
        checkOutput("rst w_valid", 32'(busIf.w_valid_o), 32'd0);
        checkOutput("rst w_strb", 32'(busIf.w_strb_o), 32'd0);
        checkOutput("rst w_last", 32'(busIf.w_last_o), 32'd0);
        checkOutput("rst w_data", busIf.w_data_o, 32'd0);
        checkOutput("rst buf_ready", 32'(busIf.buf_ready_o), 32'd0);
        checkOutput("rst burst_done", 32'(burstDone), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table of single requests");
        busIf.w_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            waitDrain();
        end

        $display("[TB] two queued requests back to back");
        busIf.w_ready_i = 1'b0;
        applyStimulus(mkVec(2'd0, 2'd0, 8'd1, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
        applyStimulus(mkVec(2'd0, 2'd0, 8'd1, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
        @(negedge clk);
        checkOutput("full dp_ready", 32'(busIf.dp_ready_o), 32'd0);
        checkOutput("full busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        busIf.w_ready_i = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (busIf.w_valid_o && busIf.w_ready_i) n++;
        end
        checkOutput("b2b consecutive beats", 32'(n), 32'd4);
        waitDrain();

        $display("[TB] backpressure on beat 1");
        doReset();
        busIf.w_ready_i = 1'b1;
        applyStimulus(mkVec(2'd0, 2'd0, 8'd2, 4'b1111, 4'b1111, 4'b1111, 4'b0000));
        @(posedge clk);
        #1;
        busIf.w_ready_i = 1'b0;
        holdData = 1'b1;
        savedData = busIf.buf_data_i;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall w_valid", 32'(busIf.w_valid_o), 32'd1);
            checkOutput("stall w_strb", 32'(busIf.w_strb_o), 32'hF);
            checkOutput("stall w_last", 32'(busIf.w_last_o), 32'd0);
            checkOutput("stall w_data", busIf.w_data_o, savedData);
            checkOutput("stall buf_ready", 32'(busIf.buf_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        busIf.w_ready_i = 1'b1;
        holdData = 1'b0;
        waitDrain();
`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
        checkOutput("stall_bp_cnt", bpCnt, 32'd5);
`endif

        $display("[TB] missing strobed lane");
        busIf.buf_valid_i = 4'b0111;
        applyStimulus(mkVec(2'd0, 2'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000));
        repeat (3) begin
            @(negedge clk);
            checkOutput("starve w_valid", 32'(busIf.w_valid_o), 32'd0);
            checkOutput("starve buf_ready", 32'(busIf.buf_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        busIf.buf_valid_i = 4'b1111;
        waitDrain();
`ifdef IDMA_W_BEAT_GEN_STALL_CNT_EN
        checkOutput("stall_data_cnt", dataCnt, 32'd3);
        checkOutput("stall_bp_cnt kept", bpCnt, 32'd5);
`endif

        $display("[TB] unstrobed lane not required");
        busIf.buf_valid_i = 4'b1110;
        applyStimulus(mkVec(2'd1, 2'd0, 8'd0, 4'b1110, 4'b0000, 4'b0000, 4'b0000));
        @(negedge clk);
        checkOutput("unstrobed w_valid", 32'(busIf.w_valid_o), 32'd1);
        waitDrain();
        busIf.buf_valid_i = 4'b1111;

        $display("[TB] reset in the middle of a burst");
        applyStimulus(mkVec(2'd0, 2'd0, 8'd3, 4'b1111, 4'b1111, 4'b1111, 4'b1111));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        busIf.w_ready_i = 1'b0;
        rstN = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("midrst w_valid", 32'(busIf.w_valid_o), 32'd0);
        checkOutput("midrst w_strb", 32'(busIf.w_strb_o), 32'd0);
        checkOutput("midrst w_last", 32'(busIf.w_last_o), 32'd0);
        checkOutput("midrst dp_ready", 32'(busIf.dp_ready_o), 32'd1);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        busIf.w_ready_i = 1'b1;
        applyStimulus(mkVec(2'd1, 2'd3, 8'd1, 4'b1110, 4'b0111, 4'b0000, 4'b0000));
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
